// File: rtl/br_pred.sv
// Branch predictor and redirect controller: 2-bit counter table (optionally gshare-indexed),
// combinational ID prediction, EX-time training and a registered one-cycle redirect pulse.
module br_pred #(
    parameter int         IDX_W   = 6,
    parameter int         GHR_W   = 0,
    parameter logic [1:0] RST_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [63:0] id_pc,
    input  logic [31:0] id_ir,
    output logic        pr_taken,
    output logic [63:0] pr_addr,
    input  logic        ex_branch,
    input  logic [63:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_miss,
    input  logic [63:0] ex_br_addr,
    input  logic        stall,
    output logic        redirect,
    output logic [63:0] redirect_addr,
    output logic [63:0] br_cnt,
    output logic [63:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] id_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             is_branch;
    logic [63:0]      b_imm;
    logic             train;
    logic             miss_set;
    logic             unused_bits;

    // EX inputs are wrong-path while a redirect is in flight, so they are masked out.
    assign train    = ex_branch & ~stall & ~redirect;
    assign miss_set = train & ex_miss;

    generate
        if (GHR_W > 0) begin : g_ghr
            logic [GHR_W-1:0] ghr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ghr <= '0;
                end else if (train) begin
                    ghr <= GHR_W'({ghr, ex_taken});
                end
            end

            assign hist = IDX_W'(ghr);
        end else begin : g_no_ghr
            assign hist = '0;
        end
    endgenerate

    assign id_idx = id_pc[IDX_W+1:2] ^ hist;
    assign ex_idx = ex_pc[IDX_W+1:2] ^ hist;

    assign is_branch = (id_ir[6:0] == 7'b1100011);
    assign b_imm     = {{51{id_ir[31]}}, id_ir[31], id_ir[7], id_ir[30:25], id_ir[11:8], 1'b0};
    assign pr_addr   = id_pc + b_imm;
    assign pr_taken  = id_valid & is_branch & table_q[id_idx][1];

    // Lookup reads the pre-update entry; no bypass from the training write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= RST_CNT;
            end
        end else if (train) begin
            if (ex_taken && table_q[ex_idx] != 2'd3) begin
                table_q[ex_idx] <= table_q[ex_idx] + 2'd1;
            end else if (!ex_taken && table_q[ex_idx] != 2'd0) begin
                table_q[ex_idx] <= table_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect      <= 1'b0;
            redirect_addr <= '0;
        end else if (!stall) begin
            redirect <= miss_set;
            if (miss_set) begin
                redirect_addr <= ex_br_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (train) begin
                br_cnt <= br_cnt + 64'd1;
            end
            if (miss_set) begin
                miss_cnt <= miss_cnt + 64'd1;
            end
        end
    end

    assign unused_bits = ^{id_ir[24:12], ex_pc[63:IDX_W+2], ex_pc[1:0]};

endmodule
